// File: rtl/regfile_port_sched.sv
// regfile_port_sched: 32x16 register bank. One read port and one write port
// are shared by pipeline reads, a writeback FIFO and a host port.
// Ports: clk, rst (sync, active-low); rd_en/rd_addr -> rd_data, rd_stall;
//   wb_valid/wb_addr/wb_data -> wb_full;
//   h_valid/h_we/h_addr/h_wdata -> h_ready, h_rvalid, h_rdata.
// Build option: RF_BYPASS_EN forwards pending writes to pipeline reads;
//   when it is undefined, reads that hit a pending write stall instead.
module regfile_port_sched #(
  parameter int WB_DEPTH      = 2,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_stall,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        wb_full,
  input  logic        h_valid,
  input  logic        h_we,
  input  logic [4:0]  h_addr,
  input  logic [15:0] h_wdata,
  output logic        h_ready,
  output logic        h_rvalid,
  output logic [15:0] h_rdata
);
  localparam int CW = $clog2(WB_DEPTH + 1);
  localparam int QS = 1 << CW;
  localparam int WW = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH = CW'(WB_DEPTH);
  localparam logic [WW-1:0] MAXW = WW'(HOST_MAX_WAIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [15:0]   bank [32];
  logic [4:0]    q_addr [QS];
  logic [15:0]   q_data [QS];
  logic [CW-1:0] count;
  logic [CW-1:0] put_idx;
  logic [WW-1:0] wait_cnt;
  logic [1:0]    state;
  logic          empty;
  logic          starved;
  logic          push;
  logic          pop;
  logic          host_wr;
  logic          host_rd_ok;
  logic          host_rd;
  logic          commit;
  logic [4:0]    c_addr;
  logic [15:0]   c_data;
  logic          hazard;
  logic [15:0]   rd_val;
  logic          rd_go;

  assign empty   = (count == '0);
  assign wb_full = (count == DEPTH);
  assign starved = (wait_cnt == MAXW);
  assign push    = wb_valid & ~wb_full;

  // Grants are masked while reset is held so a
  // pending host request never sees h_ready.
  assign host_wr = rst & (state == S_PEND)
                 & h_valid & h_we
                 & (empty | starved);
  assign host_rd_ok = (state == S_PEND)
                    & h_valid & ~h_we & empty;
  assign host_rd = rst & host_rd_ok
                 & (~rd_en | starved);
  assign h_ready = host_wr | host_rd;

  assign pop    = ~empty & ~host_wr;
  assign commit = rst & (host_wr | pop);
  assign c_addr = host_wr ? h_addr : q_addr[0];
  assign c_data = host_wr ? h_wdata : q_data[0];

  // On push+pop the new entry lands one
  // slot lower because the queue shifts.
  assign put_idx = pop ? count - 1'b1 : count;

`ifdef RF_BYPASS_EN
  always_comb begin
    rd_val = bank[rd_addr];
    if (commit && c_addr == rd_addr)
      rd_val = c_data;
    for (int i = 0; i < WB_DEPTH; i++)
      if (CW'(i) < count && q_addr[i] == rd_addr)
        rd_val = q_data[i];
    if (push && wb_addr == rd_addr)
      rd_val = wb_data;
  end
  assign hazard = 1'b0;
`else
  always_comb begin
    hazard = push && (wb_addr == rd_addr);
    for (int i = 0; i < WB_DEPTH; i++)
      if (CW'(i) < count && q_addr[i] == rd_addr)
        hazard = 1'b1;
  end
  assign rd_val = bank[rd_addr];
`endif

  assign rd_stall = rd_en
                  & (hazard | (host_rd_ok & starved));
  assign rd_go = rd_en & ~rd_stall;

  always_ff @(posedge clk) begin
    if (commit)
      bank[c_addr] <= c_data;
  end

  always_ff @(posedge clk) begin
    if (pop)
      for (int i = 0; i < QS - 1; i++) begin
        q_addr[i] <= q_addr[i+1];
        q_data[i] <= q_data[i+1];
      end
    if (push) begin
      q_addr[put_idx] <= wb_addr;
      q_data[put_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      wait_cnt <= '0;
      state    <= S_IDLE;
      rd_data  <= '0;
      h_rvalid <= 1'b0;
      h_rdata  <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (!h_valid || h_ready)
        wait_cnt <= '0;
      else if (!starved)
        wait_cnt <= wait_cnt + 1'b1;
      case (state)
        S_IDLE:
          if (h_valid) state <= S_PEND;
        S_PEND:
          if (h_ready)
            state <= h_we ? S_IDLE : S_RESP;
          else if (!h_valid)
            state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
      if (rd_go)
        rd_data <= rd_val;
      h_rvalid <= host_rd;
      if (host_rd)
        h_rdata <= bank[h_addr];
    end
  end

endmodule

// File: tb/tb_regfile_port_sched.sv
// tb_regfile_port_sched: directed bench for regfile_port_sched.
// Scenario tasks run in sequence from one initial block.
module tb_regfile_port_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_stall;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data;
  logic        wb_full;
  logic        h_valid;
  logic        h_we;
  logic [4:0]  h_addr;
  logic [15:0] h_wdata;
  logic        h_ready;
  logic        h_rvalid;
  logic [15:0] h_rdata;

  int tests = 0;
  int fails = 0;

`ifdef RF_BYPASS_EN
  localparam int RAW_STALLS = 0;
`else
  localparam int RAW_STALLS = 2;
`endif

  regfile_port_sched dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_stall(rd_stall),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_full(wb_full),
    .h_valid(h_valid), .h_we(h_we),
    .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ready(h_ready), .h_rvalid(h_rvalid),
    .h_rdata(h_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim did not finish");
    $fatal(1);
  end

  task automatic idle();
    rd_en = 0; rd_addr = '0;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    h_valid = 0; h_we = 0;
    h_addr = '0; h_wdata = '0;
  endtask

  task automatic do_host_write(
    input logic [4:0] a, input logic [15:0] d);
    int n;
    @(negedge clk);
    h_valid = 1; h_we = 1; h_addr = a; h_wdata = d;
    n = 0; #1;
    while (!h_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL host_write_timeout: no h_ready");
    end
    @(negedge clk);
    h_valid = 0; h_we = 0;
  endtask

  task automatic pipe_read(
    input logic [4:0] a, output logic [15:0] d);
    @(negedge clk);
    rd_en = 1; rd_addr = a;
    @(negedge clk);
    rd_en = 0;
    d = rd_data;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (rd_data !== 16'h0) begin fails++;
      $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    tests++;
    if (rd_stall !== 1'b0) begin fails++;
      $display("FAIL rst_rd_stall: got %b want 0", rd_stall); end
    tests++;
    if (wb_full !== 1'b0) begin fails++;
      $display("FAIL rst_wb_full: got %b want 0", wb_full); end
    tests++;
    if (h_ready !== 1'b0) begin fails++;
      $display("FAIL rst_h_ready: got %b want 0", h_ready); end
    tests++;
    if (h_rvalid !== 1'b0) begin fails++;
      $display("FAIL rst_h_rvalid: got %b want 0", h_rvalid); end
    tests++;
    if (h_rdata !== 16'h0) begin fails++;
      $display("FAIL rst_h_rdata: got %h want 0", h_rdata); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_host_write();
    int n;
    logic [15:0] d;
    @(negedge clk);
    h_valid = 1; h_we = 1;
    h_addr = 5'd3; h_wdata = 16'h1234;
    n = 0; #1;
    while (!h_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    tests++;
    if (n !== 1) begin fails++;
      $display("FAIL hw_grant_cycle: got %0d want 1", n); end
    @(negedge clk);
    h_valid = 0; h_we = 0; #1;
    tests++;
    if (h_ready !== 1'b0) begin fails++;
      $display("FAIL hw_ready_pulse: got %b want 0", h_ready); end
    pipe_read(5'd3, d);
    tests++;
    if (d !== 16'h1234) begin fails++;
      $display("FAIL hw_readback: got %h want 1234", d); end
  endtask

  task automatic test_raw_hazard();
    int n;
    @(negedge clk);
    wb_valid = 1; wb_addr = 5'd5; wb_data = 16'hAAAA;
    @(negedge clk);
    wb_data = 16'hBBBB;
    rd_en = 1; rd_addr = 5'd5;
    n = 0; #1;
    while (rd_stall && n < 20) begin
      @(negedge clk); wb_valid = 0; #1; n++;
    end
    @(negedge clk);
    wb_valid = 0; rd_en = 0;
    tests++;
    if (n !== RAW_STALLS) begin fails++;
      $display("FAIL raw_stalls: got %0d want %0d",
               n, RAW_STALLS); end
    tests++;
    if (rd_data !== 16'hBBBB) begin fails++;
      $display("FAIL raw_data: got %h want bbbb", rd_data); end
    @(negedge clk);
    tests++;
    if (rd_data !== 16'hBBBB) begin fails++;
      $display("FAIL raw_hold: got %h want bbbb", rd_data); end
  endtask

  task automatic test_write_starve_full();
    logic [15:0] d;
    do_host_write(5'd23, 16'h7777);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      h_valid = 1; h_we = 1;
      h_addr = 5'd20; h_wdata = 16'h2222;
      wb_valid = 1; wb_addr = 5'd21;
      wb_data = 16'(c + 1);
      #1;
      tests++;
      if (h_ready !== 1'b0) begin fails++;
        $display("FAIL starve_early c%0d: got %b want 0",
                 c, h_ready); end
    end
    @(negedge clk);
    wb_addr = 5'd20; wb_data = 16'h00A1;
    #1;
    tests++;
    if (h_ready !== 1'b1) begin fails++;
      $display("FAIL starve_grant: got %b want 1", h_ready); end
    tests++;
    if (wb_full !== 1'b0) begin fails++;
      $display("FAIL starve_full_c4: got %b want 0", wb_full); end
    @(negedge clk);
    h_valid = 0; h_we = 0;
    wb_addr = 5'd23; wb_data = 16'hDEAD;
    #1;
    tests++;
    if (wb_full !== 1'b1) begin fails++;
      $display("FAIL full_set: got %b want 1", wb_full); end
    tests++;
    if (h_ready !== 1'b0) begin fails++;
      $display("FAIL starve_pulse: got %b want 0", h_ready); end
    @(negedge clk);
    wb_valid = 0;
    #1;
    tests++;
    if (wb_full !== 1'b0) begin fails++;
      $display("FAIL full_clear: got %b want 0", wb_full); end
    repeat (2) @(negedge clk);
    pipe_read(5'd20, d);
    tests++;
    if (d !== 16'h00A1) begin fails++;
      $display("FAIL order_r20: got %h want 00a1", d); end
    pipe_read(5'd21, d);
    tests++;
    if (d !== 16'h0004) begin fails++;
      $display("FAIL fifo_r21: got %h want 0004", d); end
    pipe_read(5'd23, d);
    tests++;
    if (d !== 16'h7777) begin fails++;
      $display("FAIL full_drop_r23: got %h want 7777", d); end
  endtask

  task automatic test_host_read_preempt();
    int n;
    logic early;
    do_host_write(5'd7, 16'hC0DE);
    @(negedge clk);
    rd_en = 1; rd_addr = 5'd3;
    h_valid = 1; h_we = 0; h_addr = 5'd7;
    n = 0; early = 0; #1;
    while (!h_ready && n < 20) begin
      if (rd_stall) early = 1;
      @(negedge clk); #1; n++;
    end
    tests++;
    if (n !== 4) begin fails++;
      $display("FAIL hr_refused: got %0d want 4", n); end
    tests++;
    if (early !== 1'b0) begin fails++;
      $display("FAIL hr_early_stall: got %b want 0", early); end
    tests++;
    if (rd_stall !== 1'b1) begin fails++;
      $display("FAIL hr_preempt: got %b want 1", rd_stall); end
    @(negedge clk);
    h_valid = 0; #1;
    tests++;
    if (h_rvalid !== 1'b1) begin fails++;
      $display("FAIL hr_rvalid: got %b want 1", h_rvalid); end
    tests++;
    if (h_rdata !== 16'hC0DE) begin fails++;
      $display("FAIL hr_rdata: got %h want c0de", h_rdata); end
    tests++;
    if (rd_stall !== 1'b0) begin fails++;
      $display("FAIL hr_stall_end: got %b want 0", rd_stall); end
    @(negedge clk);
    rd_en = 0; #1;
    tests++;
    if (h_rvalid !== 1'b0) begin fails++;
      $display("FAIL hr_rvalid_pulse: got %b want 0", h_rvalid); end
    tests++;
    if (rd_data !== 16'h1234) begin fails++;
      $display("FAIL hr_pipe_data: got %h want 1234", rd_data); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    do_host_write(5'd25, 16'h1111);
    do_host_write(5'd26, 16'h2221);
    @(negedge clk);
    wb_valid = 1; wb_addr = 5'd25; wb_data = 16'h9999;
    h_valid = 1; h_we = 1;
    h_addr = 5'd26; h_wdata = 16'hBEEF;
    @(negedge clk);
    rst = 0; wb_data = 16'h8888; #1;
    tests++;
    if (h_ready !== 1'b0) begin fails++;
      $display("FAIL rm_h_ready: got %b want 0", h_ready); end
    @(negedge clk);
    wb_valid = 0; h_valid = 0; h_we = 0; #1;
    tests++;
    if (rd_data !== 16'h0) begin fails++;
      $display("FAIL rm_rd_data: got %h want 0", rd_data); end
    tests++;
    if (h_rdata !== 16'h0) begin fails++;
      $display("FAIL rm_h_rdata: got %h want 0", h_rdata); end
    tests++;
    if (wb_full !== 1'b0 || h_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rm_flags: got %b%b want 00",
               wb_full, h_rvalid); end
    @(negedge clk);
    rst = 1;
    pipe_read(5'd25, d);
    tests++;
    if (d !== 16'h1111) begin fails++;
      $display("FAIL rm_r25: got %h want 1111", d); end
    pipe_read(5'd26, d);
    tests++;
    if (d !== 16'h2221) begin fails++;
      $display("FAIL rm_r26: got %h want 2221", d); end
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_raw_hazard();
    test_write_starve_full();
    test_host_read_preempt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
